disp_vram_reader: RTL and testbench
===================================

Name: disp_vram_reader

Overview:
- AXI4 read master that fetches a frame from VRAM and streams it out as pixels. It is the display-side counterpart of the capture block, which writes frames into VRAM as an AXI write master.
- Reads 32-bit words (one pixel per word, RGB in bits [23:0]) from a programmable base address in fixed 16-beat INCR bursts.
- Buffers the words in an internal FIFO and presents them on a valid/ready pixel stream with start-of-frame and end-of-line marks for the downstream display timing block.

Parameters:
- BURST_LEN, 16, beats per AR burst; ARLEN = BURST_LEN-1; must divide 640.
- FIFO_DEPTH, 512, pixel FIFO entries; power of two, at least 2*BURST_LEN.
- ADDR_W, 32, AXI address width.

Ports:
- ACLK  in  1  system clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- BASEADDR  in  32  frame base byte address; bits [5:0] are ignored and forced to 0.
- RESOL  in  2  frame size: 00 = 640x480, 01 = 1024x768, 10 = 1280x1024, 11 = treated as 00.
- FRAME_START  in  1  one-cycle pulse requesting a frame fetch.
- BUSY  out  1  high from the accepted FRAME_START until the last beat of the frame is received.
- ARADDR  out  ADDR_W  burst address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARSIZE  out  3  constant 3'b010.
- ARBURST  out  2  constant 2'b01.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- RDATA  in  32  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat of the burst.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- PIX_DATA  out  24  pixel RGB.
- PIX_VALID  out  1  pixel valid.
- PIX_READY  in  1  downstream ready.
- PIX_SOF  out  1  marks the first pixel of the frame; qualified by PIX_VALID.
- PIX_EOL  out  1  marks the last pixel of each line; qualified by PIX_VALID.
- RRESP_ERR  out  1  sticky: some beat returned RRESP != 00.
- FRAME_SKIP  out  1  sticky: a FRAME_START arrived while BUSY.
- ERR_CLR  in  1  clears both sticky flags; a set on the same cycle wins.

Behaviour:
- Reset: every output is 0 except the constants ARLEN, ARSIZE and ARBURST. The FIFO is emptied and all counters are zeroed. Reset asserted mid-burst abandons the transaction; the slave is reset on the same signal.
- FSM states: IDLE, WAIT_SPACE, ADDR, DATA.
- IDLE:
  - On FRAME_START, latch BASEADDR and RESOL.
  - Set total_bursts = pixels / BURST_LEN.
  - Clear burst_idx, set BUSY, go to WAIT_SPACE.
- WAIT_SPACE:
  - Stay until FIFO free entries >= BURST_LEN, counting entries already promised by the burst in flight.
  - Then drive ARADDR = base + burst_idx*BURST_LEN*4 and ARVALID=1, go to ADDR.
- ADDR:
  - Hold ARVALID, ARADDR stable until ARREADY.
  - On the handshake: ARVALID=0, go to DATA.
- DATA:
  - RREADY=1 throughout; this cannot overflow the FIFO because space was reserved.
  - Each RVALID&RREADY beat pushes RDATA[23:0] into the FIFO.
  - RRESP != 00 sets RRESP_ERR; the data is still pushed.
  - On the RLAST beat: increment burst_idx. If burst_idx becomes total_bursts, clear BUSY and go to IDLE; otherwise go to WAIT_SPACE.
- Burst issue rules:
  - Only one burst is outstanding at a time.
  - A 64-byte-aligned base means no burst crosses a 4 KB boundary.
- Output stream:
  - The FIFO is first-word-fall-through.
  - PIX_VALID = FIFO not empty; a pop happens on PIX_VALID&PIX_READY.
  - PIX_DATA, PIX_SOF and PIX_EOL must hold stable while PIX_VALID && !PIX_READY.
- Pixel counters:
  - An x counter (width from the latched RESOL) and a y counter advance per popped pixel.
  - PIX_SOF = (x==0 && y==0); PIX_EOL = (x==width-1).
  - After the last pixel of the frame, x and y wrap to 0.
- Boundaries:
  - FRAME_START while BUSY is ignored and sets FRAME_SKIP.
  - FRAME_START on the same cycle BUSY falls is ignored.
  - A new frame may start while the FIFO still holds pixels of the previous frame. The output counters keep running and wrap naturally.
  - PIX_READY held low stalls fetching in WAIT_SPACE; no data is lost.
- Latency: at least 1 cycle from the IDLE-state FRAME_START to ARVALID, and 1 cycle from the RDATA beat to PIX_VALID.

Decomposition:
- disp_pkg holds:
  - the RESOL encodings P_RESOL_VGA/XGA/SXGA;
  - the width/height constants and the function pixels(resol);
  - the AXI constants (ARSIZE_4B, ARBURST_INCR, RESP_OKAY);
  - the FSM state enum.
- Sub-module disp_pix_fifo: synchronous first-word-fall-through FIFO, DATA_W=26 carrying {sof,eol,rgb}, FIFO_DEPTH deep. It provides full, empty and count outputs.
- The SOF/EOL tags are computed at the pop side from counters. The FIFO may store only rgb; in that case DATA_W=24.

Test Plan:
- VGA, BASEADDR=0x2000_0000, memory word i = i, PIX_READY=1 -> exactly 19200 AR bursts, with ARADDR stepping by 0x40 up to 0x2012_BFC0. PIX_DATA sequence is 0..307199. PIX_SOF once, PIX_EOL every 640th pixel, BUSY falls after the last RLAST.
- XGA with random ARREADY/RVALID and random PIX_READY at 30% -> 786432 pixels in order, with no drop or duplication. PIX_EOL every 1024th pixel; outputs stable while stalled.
- PIX_READY=0 for 5000 cycles after start -> the FIFO fills to FIFO_DEPTH and ARVALID stops in WAIT_SPACE. No RREADY beat is lost, and the stream resumes correctly on release.
- FRAME_START pulsed mid-frame -> FRAME_SKIP=1 and the frame continues unchanged. ERR_CLR -> FRAME_SKIP=0.
- Slave returns RRESP=2'b10 on burst 3 -> RRESP_ERR=1 and all 16 beats are still output.
- ARESET asserted in DATA state -> all outputs 0 and the FIFO empty immediately. A subsequent FRAME_START fetches from burst 0.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display VRAM reader.
//   - RESOL encodings and per-resolution line width / frame height
//   - pixels(resol): total pixels in a frame
//   - AXI read constants
//   - reader FSM state encoding
package disp_pkg;

    localparam logic [1:0] P_RESOL_VGA  = 2'b00;
    localparam logic [1:0] P_RESOL_XGA  = 2'b01;
    localparam logic [1:0] P_RESOL_SXGA = 2'b10;

    // Wide enough for 1280*1024 pixels and for x/y coordinates up to 1279.
    localparam int PIX_CNT_W = 21;
    localparam int XY_W      = 11;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_ADDR       = 2'd2,
        ST_DATA       = 2'd3
    } disp_state_t;

    // RESOL 2'b11 falls into the default arm and behaves as VGA.
    function automatic logic [XY_W-1:0] line_width(input logic [1:0] resol);
        case (resol)
            P_RESOL_XGA:  return 11'd1024;
            P_RESOL_SXGA: return 11'd1280;
            default:      return 11'd640;
        endcase
    endfunction

    function automatic logic [XY_W-1:0] frame_height(input logic [1:0] resol);
        case (resol)
            P_RESOL_XGA:  return 11'd768;
            P_RESOL_SXGA: return 11'd1024;
            default:      return 11'd480;
        endcase
    endfunction

    function automatic logic [PIX_CNT_W-1:0] pixels(input logic [1:0] resol);
        return PIX_CNT_W'(line_width(resol)) * PIX_CNT_W'(frame_height(resol));
    endfunction

endpackage

// File: rtl/disp_vram_reader_fifo.sv
// disp_pix_fifo: synchronous first-word-fall-through FIFO for pixel RGB.
//   clk_i/rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop the head entry (ignored when empty)
//   rdata_o     : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
module disp_pix_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head is read combinationally so data is presented with no pop latency.
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/disp_vram_reader.sv
// disp_vram_reader: AXI4 read master fetching a frame from VRAM in fixed
// BURST_LEN-beat INCR bursts and streaming it out as tagged pixels.
//   ACLK/ARESET          : clock, asynchronous active-high reset
//   BASEADDR/RESOL       : frame base (64-byte aligned) and size, latched on FRAME_START
//   FRAME_START/BUSY     : frame request pulse / frame fetch in progress
//   AR*/R*               : AXI4 read address and read data channels
//   PIX_*                : pixel stream with SOF/EOL marks
//   RRESP_ERR/FRAME_SKIP : sticky error flags, cleared by ERR_CLR
//   DBG_STATE            : current fetch FSM state
//
// Handshakes: a transfer happens on every rising edge where valid and ready
// are both high; once valid is raised the payload holds until that edge.
module disp_vram_reader
    import disp_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [31:0]       BASEADDR,
    input  logic [1:0]        RESOL,
    input  logic              FRAME_START,
    output logic              BUSY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [23:0]       PIX_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              PIX_SOF,
    output logic              PIX_EOL,
    output logic              RRESP_ERR,
    output logic              FRAME_SKIP,
    input  logic              ERR_CLR,
    output disp_state_t       DBG_STATE
);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);

    disp_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d, araddr_q, araddr_d;
    logic                 arvalid_q, arvalid_d, busy_q, busy_d;
    logic [1:0]           resol_q, resol_d;
    logic [PIX_CNT_W-1:0] total_q, total_d, idx_q, idx_d, idx_inc;
    logic [XY_W-1:0]      x_q, x_d, y_q, y_d, line_w, frame_h;
    logic                 rresp_err_q, frame_skip_q;

    logic                 beat, fifo_push, pix_pop;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [23:0]          fifo_rdata;
    logic                 unused_bits;

    assign unused_bits = ^{BASEADDR[5:0], RDATA[31:24]};

    assign beat      = (state_q == ST_DATA) && RVALID;
    assign fifo_push = beat && !fifo_full;
    assign pix_pop   = !fifo_empty && PIX_READY;
    assign idx_inc   = idx_q + 1'b1;

    disp_pix_fifo #(
        .DATA_W (24),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (fifo_push),
        .wdata_i (RDATA[23:0]),
        .pop_i   (pix_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Fetch FSM. A burst is only requested once the whole burst fits in the
    // FIFO; with one burst outstanding, RREADY can then stay high in DATA.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        resol_d   = resol_q;
        total_d   = total_q;
        idx_d     = idx_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (FRAME_START) begin
                    base_d  = ADDR_W'({BASEADDR[31:6], 6'b0});
                    resol_d = RESOL;
                    total_d = PIX_CNT_W'(pixels(RESOL) / PIX_CNT_W'(BURST_LEN));
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if ((CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(BURST_LEN)) begin
                    araddr_d  = base_q + ADDR_W'(idx_q) * BURST_BYTES;
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat && RLAST) begin
                    idx_d = idx_inc;
                    if (idx_inc == total_q) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_SPACE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output-side raster position; wraps to (0,0) after the last pixel.
    assign line_w  = line_width(resol_q);
    assign frame_h = frame_height(resol_q);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_pop) begin
            if (x_q == line_w - 1'b1) begin
                x_d = '0;
                y_d = (y_q == frame_h - 1'b1) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            resol_q      <= P_RESOL_VGA;
            total_q      <= '0;
            idx_q        <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            rresp_err_q  <= 1'b0;
            frame_skip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            resol_q      <= resol_d;
            total_q      <= total_d;
            idx_q        <= idx_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            busy_q       <= busy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            // A new error on the clear cycle keeps the flag set.
            rresp_err_q  <= (rresp_err_q && !ERR_CLR) || (beat && (RRESP != RESP_OKAY));
            frame_skip_q <= (frame_skip_q && !ERR_CLR) || (FRAME_START && busy_q);
        end
    end

    assign BUSY       = busy_q;
    assign ARADDR     = araddr_q;
    assign ARLEN      = 8'(BURST_LEN - 1);
    assign ARSIZE     = ARSIZE_4B;
    assign ARBURST    = ARBURST_INCR;
    assign ARVALID    = arvalid_q;
    assign RREADY     = (state_q == ST_DATA);
    assign PIX_VALID  = !fifo_empty;
    // Gated so that an empty FIFO never shows stale memory contents.
    assign PIX_DATA   = fifo_empty ? 24'd0 : fifo_rdata;
    assign PIX_SOF    = !fifo_empty && (x_q == '0) && (y_q == '0);
    assign PIX_EOL    = !fifo_empty && (x_q == line_w - 1'b1);
    assign RRESP_ERR  = rresp_err_q;
    assign FRAME_SKIP = frame_skip_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_disp_vram_reader.sv
// Directed bench for disp_vram_reader: AXI slave model returning
// word (addr>>2), pixel scoreboard with an expected queue, and a
// handful of directed frames (full-speed VGA, random-stall XGA,
// back-pressure fill, mid-frame reset).
module tb_disp_vram_reader;
    import disp_pkg::*;

    localparam int BURST_LEN  = 16;
    localparam int FIFO_DEPTH = 512;
    localparam int ADDR_W     = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic [31:0]       base_addr;
    logic [1:0]        resol;
    logic              frame_start;
    logic              busy;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic [23:0]       pix_data;
    logic              pix_valid, pix_ready, pix_sof, pix_eol;
    logic              rresp_err, frame_skip, err_clr;
    disp_state_t       dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] tb_base;
    int          ar_pct, r_pct, pix_pct, err_burst;
    int          ar_count, beat_count, beat, cur_burst;
    bit          in_flight;
    logic [31:0] burst_addr;
    logic [26:0] exp_q[$];

    always #5 aclk = ~aclk;

    disp_vram_reader #(
        .BURST_LEN (BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .ACLK(aclk), .ARESET(areset), .BASEADDR(base_addr), .RESOL(resol),
        .FRAME_START(frame_start), .BUSY(busy), .ARADDR(araddr), .ARLEN(arlen),
        .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
        .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_READY(pix_ready),
        .PIX_SOF(pix_sof), .PIX_EOL(pix_eol), .RRESP_ERR(rresp_err),
        .FRAME_SKIP(frame_skip), .ERR_CLR(err_clr), .DBG_STATE(dbg_state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},       32'(busy), 0);
        check_val({tag, "_arvalid"},    32'(arvalid), 0);
        check_val({tag, "_araddr"},     araddr, 0);
        check_val({tag, "_rready"},     32'(rready), 0);
        check_val({tag, "_pix_valid"},  32'(pix_valid), 0);
        check_val({tag, "_pix_data"},   32'(pix_data), 0);
        check_val({tag, "_pix_sof"},    32'(pix_sof), 0);
        check_val({tag, "_pix_eol"},    32'(pix_eol), 0);
        check_val({tag, "_rresp_err"},  32'(rresp_err), 0);
        check_val({tag, "_frame_skip"}, 32'(frame_skip), 0);
        check_val({tag, "_arlen"},      32'(arlen), 15);
        check_val({tag, "_arsize"},     32'(arsize), 2);
        check_val({tag, "_arburst"},    32'(arburst), 1);
    endtask

    // Expected stream {valid, sof, eol, rgb}; VRAM word i of the frame holds (base>>2)+i.
    task automatic fill_exp(input logic [31:0] base, input int n, input int w);
        logic [31:0] word0;
        logic [23:0] rgb;
        word0 = base >> 2;
        for (int i = 0; i < n; i++) begin
            rgb = 24'(word0 + 32'(i));
            exp_q.push_back({1'b1, (i == 0), ((i % w) == (w - 1)), rgb});
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [1:0] res);
        @(posedge aclk);
        #1;
        base_addr   = base;
        resol       = res;
        frame_start = 1'b1;
        @(posedge aclk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(posedge aclk);
            c++;
        end
        check_val(tag, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // AXI read slave: one burst at a time, data = {8'hA5, addr[25:2]}.
    initial begin
        bit          ar_fire, r_fire, r_last_s;
        logic [31:0] ar_addr_s;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
        in_flight = 1'b0; beat = 0; ar_count = 0; beat_count = 0; cur_burst = 0;
        burst_addr = '0;
        forever begin
            @(negedge aclk);
            ar_fire   = arvalid && arready;
            r_fire    = rvalid && rready;
            r_last_s  = rlast;
            ar_addr_s = araddr;
            @(posedge aclk);
            #1;
            if (areset) begin
                in_flight = 1'b0; beat = 0; ar_count = 0; beat_count = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
            end else begin
                if (r_fire) begin
                    beat_count++;
                    beat++;
                    if (r_last_s) in_flight = 1'b0;
                end
                if (ar_fire) begin
                    check_val("ar_one_outstanding", 32'(in_flight), 0);
                    check_val("araddr", ar_addr_s, tb_base + 32'(ar_count) * 32'd64);
                    burst_addr = ar_addr_s;
                    cur_burst  = ar_count;
                    ar_count++;
                    in_flight  = 1'b1;
                    beat       = 0;
                end
                arready = ($urandom_range(1, 100) <= ar_pct);
                if (in_flight) begin
                    rvalid = (rvalid && !r_fire) ? 1'b1 : ($urandom_range(1, 100) <= r_pct);
                    rdata  = {8'hA5, 24'((burst_addr >> 2) + 32'(beat))};
                    rlast  = (beat == BURST_LEN - 1);
                    rresp  = (cur_burst == err_burst) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    rresp  = 2'b00;
                end
            end
        end
    end

    // Downstream ready driver.
    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            pix_ready = ($urandom_range(1, 100) <= pix_pct);
        end
    end

    // Pixel scoreboard and hold-while-stalled check.
    initial begin
        bit          prev_stall;
        logic [26:0] prev_v, cur_v, exp_v;
        prev_stall = 1'b0;
        prev_v     = '0;
        forever begin
            @(negedge aclk);
            cur_v = {pix_valid, pix_sof, pix_eol, pix_data};
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check_val("pix_stable", 32'(cur_v), 32'(prev_v));
                if (pix_valid && pix_ready && exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check_val("pixel", 32'(cur_v), 32'(exp_v));
                end
                prev_stall = pix_valid && !pix_ready;
                prev_v     = cur_v;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        areset = 1'b1; base_addr = '0; resol = '0; frame_start = 1'b0; err_clr = 1'b0;
        tb_base = '0; err_burst = -1; ar_pct = 100; r_pct = 100; pix_pct = 100;
        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs("rst0");
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // VGA at full speed, error response on burst 3, mid-frame restart request.
        tb_base   = 32'h2000_0000;
        err_burst = 3;
        fill_exp(tb_base, 1300, 640);
        start_frame(tb_base, P_RESOL_VGA);
        check_val("t1_busy_set", 32'(busy), 1);
        repeat (200) @(posedge aclk);
        #1;
        check_val("t1_rresp_err", 32'(rresp_err), 1);
        check_val("t1_skip_clear", 32'(frame_skip), 0);
        start_frame(32'h0, P_RESOL_XGA);
        check_val("t1_skip_set", 32'(frame_skip), 1);
        check_val("t1_busy_held", 32'(busy), 1);
        @(posedge aclk);
        #1;
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        check_val("t1_skip_cleared", 32'(frame_skip), 0);
        check_val("t1_err_cleared", 32'(rresp_err), 0);
        wait_drain("t1_drain", 4000);
        c = 0;
        while (dbg_state != ST_DATA && c < 100) begin
            @(posedge aclk);
            #1;
            c++;
        end
        check_val("t1_in_data", 32'(dbg_state), 32'(ST_DATA));
        apply_reset("rst_data");

        // XGA with random AR/R timing and 30% downstream ready.
        tb_base   = 32'h0001_0040;
        err_burst = -1;
        ar_pct = 50; r_pct = 60; pix_pct = 30;
        fill_exp(tb_base, 2100, 1024);
        start_frame(tb_base, P_RESOL_XGA);
        wait_drain("t2_drain", 20000);
        check_val("t2_busy", 32'(busy), 1);
        check_val("t2_no_err", 32'(rresp_err), 0);
        check_val("t2_no_skip", 32'(frame_skip), 0);
        apply_reset("rst_t2");

        // Downstream stalled: FIFO fills and fetching parks in WAIT_SPACE.
        tb_base = 32'h0;
        ar_pct = 100; r_pct = 100; pix_pct = 0;
        fill_exp(tb_base, 1000, 640);
        start_frame(tb_base, P_RESOL_VGA);
        repeat (5000) @(posedge aclk);
        #1;
        check_val("t3_state", 32'(dbg_state), 32'(ST_WAIT_SPACE));
        check_val("t3_arvalid", 32'(arvalid), 0);
        check_val("t3_bursts", 32'(ar_count), FIFO_DEPTH / BURST_LEN);
        check_val("t3_beats", 32'(beat_count), FIFO_DEPTH);
        check_val("t3_pix_valid", 32'(pix_valid), 1);
        check_val("t3_pix_sof", 32'(pix_sof), 1);
        check_val("t3_unpopped", 32'(exp_q.size()), 1000);
        pix_pct = 100;
        wait_drain("t3_drain", 3000);
        check_val("t3_resumed", 32'(ar_count > FIFO_DEPTH / BURST_LEN), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
